// File: rtl/insight_tap_scheduler.sv
// Change-driven tap sampler with round-robin arbitration onto one valid/ready record stream.
// Optional capture timestamps: define INSIGHT_TAP_SCHED_TIMESTAMP_EN.
//   state | meaning
//   IDLE  | sampling off, pending slots held empty
//   ARM   | one cycle: prime shadows from live taps, no events
//   RUN   | change detection and capture active
module insight_tap_scheduler #(
  parameter int NUM_TAPS = 4,
  parameter int TAP_W    = 8,
  parameter int TS_W     = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NUM_TAPS*TAP_W-1:0]     tap_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_TAPS)-1:0]   out_id,
  output logic [TAP_W-1:0]              out_data,
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
  output logic [TS_W-1:0]               out_ts,
`endif
  output logic [NUM_TAPS-1:0]           lost,
  input  logic                          lost_clear
);

  localparam int ID_W = $clog2(NUM_TAPS);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [TAP_W-1:0]    tap_w      [NUM_TAPS];
  logic [TAP_W-1:0]    shadow_q   [NUM_TAPS];
  logic [TAP_W-1:0]    shadow_d   [NUM_TAPS];
  logic [TAP_W-1:0]    pend_val_q [NUM_TAPS];
  logic [TAP_W-1:0]    pend_val_d [NUM_TAPS];
  logic [NUM_TAPS-1:0] pending_q, pending_d;
  logic [NUM_TAPS-1:0] lost_q, lost_d, lost_set;
  logic [NUM_TAPS-1:0] chg;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic                out_valid_q, out_valid_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic [TAP_W-1:0]    out_data_q, out_data_d;
  logic [ID_W:0]       pick_r;
  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  logic                load_en;
  logic                take;

`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [TS_W-1:0]     pend_ts_q [NUM_TAPS];
  logic [TS_W-1:0]     pend_ts_d [NUM_TAPS];
  logic [TS_W-1:0]     out_ts_q, out_ts_d;
`else
  logic                unused_ts_w;
  assign unused_ts_w = ^{TS_W{1'b0}};
`endif

  // First set bit of pend scanning upward from ptr, wrapping; MSB flags a hit.
  function automatic logic [ID_W:0] pick(input logic [NUM_TAPS-1:0] pend,
                                         input logic [ID_W-1:0]     ptr);
    logic [ID_W:0] r;
    int            j;
    r = '0;
    for (int k = NUM_TAPS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_TAPS) j = j - NUM_TAPS;
      if (pend[j[ID_W-1:0]]) r = {1'b1, ID_W'(j)};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      tap_w[i] = tap_data[i*TAP_W +: TAP_W];
      chg[i]   = (tap_w[i] != shadow_q[i]);
    end
  end

  assign pick_r    = pick(pending_q, rr_q);
  assign gnt_found = pick_r[ID_W];
  assign gnt_idx   = pick_r[ID_W-1:0];
  assign load_en   = !out_valid_q || out_ready;
  assign take      = load_en && gnt_found;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    pend_val_d  = pend_val_q;
    pending_d   = pending_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    lost_set    = '0;
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
    ts_d        = ts_q;
    pend_ts_d   = pend_ts_q;
    out_ts_d    = out_ts_q;
`endif

    if (load_en) begin
      if (gnt_found) begin
        out_valid_d        = 1'b1;
        out_id_d           = gnt_idx;
        out_data_d         = pend_val_q[gnt_idx];
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
        out_ts_d           = pend_ts_q[gnt_idx];
`endif
        pending_d[gnt_idx] = 1'b0;
        rr_d = (int'(gnt_idx) == NUM_TAPS - 1) ? '0 : gnt_idx + ID_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        pending_d = '0;
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        pending_d = '0;
        shadow_d  = tap_w;
        state_d   = enable ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
        ts_d = ts_q + TS_W'(1);
`endif
        if (!enable) begin
          state_d   = ST_IDLE;
          pending_d = '0;
        end else begin
          for (int i = 0; i < NUM_TAPS; i++) begin
            if (chg[i]) begin
              shadow_d[i]   = tap_w[i];
              pend_val_d[i] = tap_w[i];
              pending_d[i]  = 1'b1;
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
              pend_ts_d[i]  = ts_q;
`endif
              // A slot granted this cycle frees up, so the new value is not an overwrite.
              if (pending_q[i] && !(take && gnt_idx == ID_W'(i))) lost_set[i] = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    lost_d = (lost_clear ? '0 : lost_q) | lost_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      lost_q      <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow_q[i]   <= '0;
        pend_val_q[i] <= '0;
      end
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
      ts_q     <= '0;
      out_ts_q <= '0;
      for (int i = 0; i < NUM_TAPS; i++) pend_ts_q[i] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      lost_q      <= lost_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      shadow_q    <= shadow_d;
      pend_val_q  <= pend_val_d;
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
      ts_q        <= ts_d;
      out_ts_q    <= out_ts_d;
      pend_ts_q   <= pend_ts_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign lost      = lost_q;
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
  assign out_ts    = out_ts_q;
`endif

endmodule

// File: tb/tb_insight_tap_scheduler.sv
// Bench for insight_tap_scheduler: vector table plus hand sequences, records checked via a scoreboard queue.
module tb_insight_tap_scheduler;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int TS_W = 16;
  localparam int ID_W = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [N*W-1:0]   tap_data;
  logic             out_valid;
  logic             out_ready;
  logic [ID_W-1:0]  out_id;
  logic [W-1:0]     out_data;
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
  logic [TS_W-1:0]  out_ts;
`endif
  logic [N-1:0]     lost;
  logic             lost_clear;

  insight_tap_scheduler #(.NUM_TAPS(N), .TAP_W(W), .TS_W(TS_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .tap_data   (tap_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_data   (out_data),
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
    .out_ts     (out_ts),
`endif
    .lost       (lost),
    .lost_clear (lost_clear)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [W-1:0]    data;
    logic [TS_W-1:0] ts;
    bit              chk_ts;
  } rec_t;

  typedef struct {
    logic [N*W-1:0]        taps;
    int                    n;
    logic [3:0][ID_W-1:0]  ids;
    logic [3:0][W-1:0]     dats;
  } vec_t;

  rec_t sb[$];
  int   hs_q[$];
  rec_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  vec_t vecs[8];

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Handshake completes at the following posedge; sample here, half a cycle away.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      hs_q.push_back(cyc);
      if (sb.size() == 0) begin
        check("record_expected", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check("rec_id", 64'(out_id), 64'(mon_e.id));
        check("rec_data", 64'(out_data), 64'(mon_e.data));
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
        if (mon_e.chk_ts) check("rec_ts", 64'(out_ts), 64'(mon_e.ts));
`endif
      end
    end
  end

  task automatic push_rec(input int id, input logic [W-1:0] d,
                          input logic [TS_W-1:0] ts, input bit c);
    rec_t r;
    r.id = ID_W'(id); r.data = d; r.ts = ts; r.chk_ts = c;
    sb.push_back(r);
  endtask

  task automatic set_tap(input int ch, input logic [W-1:0] v);
    tap_data[ch*W +: W] = v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    do begin
      @(posedge clock);
      i++;
    end while (sb.size() != 0 && i < budget);
    #1;
    check({"drain_", name}, 64'(sb.size()), 64'd0);
  endtask

  function automatic vec_t mk(input logic [N*W-1:0] t, input int n,
                              input int i0, input logic [W-1:0] d0,
                              input int i1, input logic [W-1:0] d1,
                              input int i2, input logic [W-1:0] d2,
                              input int i3, input logic [W-1:0] d3);
    vec_t v;
    v.taps = t; v.n = n;
    v.ids[0] = ID_W'(i0); v.dats[0] = d0;
    v.ids[1] = ID_W'(i1); v.dats[1] = d1;
    v.ids[2] = ID_W'(i2); v.dats[2] = d2;
    v.ids[3] = ID_W'(i3); v.dats[3] = d3;
    return v;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [W-1:0] nv;

    // Taps are 5A everywhere after priming; expected grant order derived from rr_ptr by hand.
    vecs[0] = mk(32'h5A5B5A5A, 1, 2, 8'h5B, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    vecs[1] = mk(32'h775B5A5A, 1, 3, 8'h77, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    vecs[2] = mk(32'h01020304, 4, 0, 8'h04, 1, 8'h03, 2, 8'h02, 3, 8'h01);
    vecs[3] = mk(32'hA1B2C3D4, 4, 0, 8'hD4, 1, 8'hC3, 2, 8'hB2, 3, 8'hA1);
    vecs[4] = mk(32'h11B2EED4, 2, 1, 8'hEE, 3, 8'h11, 0, 8'h00, 0, 8'h00);
    vecs[5] = mk(32'h1155EE99, 2, 0, 8'h99, 2, 8'h55, 0, 8'h00, 0, 8'h00);
    vecs[6] = mk(32'h2255EE88, 2, 3, 8'h22, 0, 8'h88, 0, 8'h00, 0, 8'h00);
    vecs[7] = mk(32'h22554477, 2, 1, 8'h44, 0, 8'h77, 0, 8'h00, 0, 8'h00);

    reset_n = 1'b0; enable = 1'b0; out_ready = 1'b1; lost_clear = 1'b0;
    tap_data = {N{8'h5A}};
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_lost", 64'(lost), 64'd0);
`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
    check("rst_out_ts", 64'(out_ts), 64'd0);
`endif
    @(posedge clock); #1;
    reset_n = 1'b1;
    tick(2);

    // Shadows start at 0 while taps sit at 5A: ARM must prime them.
    enable = 1'b1;
    tick(6);
    check("arm_no_record", 64'(out_valid), 64'd0);

    for (int v = 0; v < 8; v++) begin
      hs_q.delete();
      tap_data = vecs[v].taps;
      t0 = cyc;
      for (int j = 0; j < vecs[v].n; j++) push_rec(int'(vecs[v].ids[j]), vecs[v].dats[j], '0, 1'b0);
      wait_drain($sformatf("vec%0d", v), 20);
      check($sformatf("vec%0d_count", v), 64'(hs_q.size()), 64'(vecs[v].n));
      if (hs_q.size() >= 1) check($sformatf("vec%0d_latency", v), 64'(hs_q[0] - t0), 64'd2);
      if (vecs[v].n > 1 && hs_q.size() == vecs[v].n)
        check($sformatf("vec%0d_back_to_back", v), 64'(hs_q[vecs[v].n-1] - hs_q[0]), 64'(vecs[v].n - 1));
      tick(2);
      check($sformatf("vec%0d_idle_after", v), 64'(out_valid), 64'd0);
    end

    // Backpressure: ch3 occupies the output register while ch1 is overwritten twice.
    out_ready = 1'b0;
    set_tap(3, 8'h99); tick(1);
    set_tap(1, 8'h10); tick(1);
    set_tap(1, 8'h11); tick(1);
    set_tap(1, 8'h12); tick(1);
    check("bp_lost", 64'(lost), 64'h2);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_hold_id", 64'(out_id), 64'd3);
    tick(3);
    check("bp_hold_data", 64'(out_data), 64'h99);
    push_rec(3, 8'h99, '0, 1'b0);
    push_rec(1, 8'h12, '0, 1'b0);
    out_ready = 1'b1;
    wait_drain("bp", 20);
    lost_clear = 1'b1; tick(1); lost_clear = 1'b0;
    check("lost_clear", 64'(lost), 64'd0);

    // Overwrite coinciding with lost_clear: the set wins.
    out_ready = 1'b0;
    set_tap(3, 8'h9A); tick(1);
    set_tap(1, 8'h20); tick(1);
    set_tap(1, 8'h21); lost_clear = 1'b1; tick(1); lost_clear = 1'b0;
    check("lost_set_wins", 64'(lost), 64'h2);
    push_rec(3, 8'h9A, '0, 1'b0);
    push_rec(1, 8'h21, '0, 1'b0);
    out_ready = 1'b1;
    wait_drain("set_wins", 20);
    lost_clear = 1'b1; tick(1); lost_clear = 1'b0;

    // Grant of ch0 coincides with its next change.
    set_tap(0, 8'h30); tick(1);
    set_tap(0, 8'h33);
    push_rec(0, 8'h30, '0, 1'b0);
    push_rec(0, 8'h33, '0, 1'b0);
    wait_drain("grant_change", 20);
    check("grant_change_lost", 64'(lost), 64'd0);

    enable = 1'b0; tick(2);
    set_tap(2, 8'h66); tick(4);
    check("idle_no_capture", 64'(out_valid), 64'd0);

    // Reset mid-run with a stalled record and pending = 0101.
    enable = 1'b1; tick(4);
    out_ready = 1'b0;
    set_tap(3, 8'hC3); tick(1);
    set_tap(0, 8'hC0); set_tap(2, 8'hC2); tick(1);
    set_tap(0, 8'hC1); tick(1);
    check("pre_rst_lost", 64'(lost), 64'h1);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #1; reset_n = 1'b0; enable = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_id", 64'(out_id), 64'd0);
    check("async_rst_data", 64'(out_data), 64'd0);
    check("async_rst_lost", 64'(lost), 64'd0);
    #4; reset_n = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b1;
    set_tap(1, 8'hD1); tick(5);
    check("post_rst_no_record", 64'(out_valid), 64'd0);
    enable = 1'b1; tick(5);
    check("post_rst_arm_no_record", 64'(out_valid), 64'd0);
    set_tap(1, 8'hE1);
    push_rec(1, 8'hE1, '0, 1'b0);
    wait_drain("post_rst", 20);

`ifdef INSIGHT_TAP_SCHED_TIMESTAMP_EN
    // RUN cycle k carries counter value k; counter starts at 0 after reset.
    #1; reset_n = 1'b0; enable = 1'b0;
    #2; reset_n = 1'b1;
    @(posedge clock); #1;
    enable = 1'b1;
    tick(2);
    for (int k = 0; k <= (1 << TS_W) + 1; k++) begin
      if (k == 5 || k == 9 || k == (1 << TS_W) - 1 || k == (1 << TS_W)) begin
        int ch;
        ch = (k == 5) ? 0 : (k == 9) ? 1 : (k == (1 << TS_W) - 1) ? 2 : 3;
        nv = tap_data[ch*W +: W] ^ 8'hFF;
        set_tap(ch, nv);
        push_rec(ch, nv, TS_W'(k), 1'b1);
      end
      tick(1);
    end
    wait_drain("ts", 20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
